lantern_multi: RTL and testbench
================================

LANTERN_MULTI -- requirements
Module: lantern_multi

Interface
REQ-001 The block SHALL have parameter N_LED, default 18, giving the LED count (minimum 2).
REQ-002 The block SHALL have parameter BASE_DIV, default 5000000, giving clk cycles per step at speed 0.
REQ-003 The block SHALL have parameter STEP_DIV, default 500000, giving cycles removed from the step period per speed unit.
REQ-004 The block SHALL have parameter MIN_DIV, default 1000, giving the minimum step period in cycles (at least 2).
REQ-005 The block SHALL have parameter SPEED_W, default 16, giving the speed input width.
REQ-006 clk  input  1  single system clock; all state changes on its rising edge.
REQ-007 rst  input  1  asynchronous, active-low reset.
REQ-008 stop  input  1  pause: 1 holds the pattern and the step counter.
REQ-009 mode  input  2  00 shift-right, 01 shift-left, 10 bounce, 11 bar-fill.
REQ-010 speed  input  SPEED_W  unsigned speed setting.
REQ-011 led  output  N_LED  LED pattern, registered.
REQ-012 step  output  1  one-cycle pulse on every pattern update.
REQ-013 wrap  output  1  one-cycle pulse, coincident with step, when a pattern cycle restarts.

Function
REQ-014 Period P SHALL be BASE_DIV - speed*STEP_DIV, computed at no less than 32 bits, and SHALL saturate to MIN_DIV when speed*STEP_DIV > BASE_DIV - MIN_DIV.
REQ-015 The step counter SHALL increment each clk while stop=0; when count >= P-1 it SHALL clear to 0 and assert step for that cycle.
REQ-016 A speed change that makes count >= P-1 SHALL produce step on the next clk; no step SHALL be lost or doubled.
REQ-017 While stop=1, the counter, led, mode register and direction SHALL hold, and step and wrap SHALL stay 0.
REQ-018 On each step, mode SHALL be sampled. If it differs from the registered mode, led SHALL load that mode's start pattern, direction SHALL reset to down, and wrap SHALL stay 0.
REQ-019 The start pattern SHALL be bit N_LED-1 only for modes 00, 10 and 11, and bit 0 only for mode 01.
REQ-020 Mode 00: the single lit bit SHALL move one position toward bit 0; from bit 0 it SHALL move to bit N_LED-1 with wrap=1. All N_LED positions SHALL be visited.
REQ-021 Mode 01: the single lit bit SHALL move toward bit N_LED-1; from bit N_LED-1 it SHALL move to bit 0 with wrap=1.
REQ-022 Mode 10: the lit bit SHALL move in the current direction and reverse at bit 0 and at bit N_LED-1, so each end is shown for exactly one step; the return to bit N_LED-1 SHALL assert wrap. Cycle length is 2*(N_LED-1) steps.
REQ-023 Mode 11: each step SHALL set the highest unlit bit; from all-ones the next step SHALL load bit N_LED-1 only with wrap=1. Cycle length is N_LED steps.
REQ-024 If led ever holds an illegal pattern (zero bits set in modes 00/01/10, or not a contiguous-from-MSB run in mode 11), the next step SHALL load the start pattern with wrap=0.

Reset
REQ-025 While rst=0, asynchronously: led SHALL be bit N_LED-1 only, counter 0, registered mode 00, direction down, step=0, wrap=0.
REQ-026 After rst release, the first step SHALL occur P clk cycles later; reset mid-period SHALL discard the partial count.

Configuration
REQ-027 With macro LANTERN_BOUNCE_EN defined, mode 10 SHALL behave per REQ-022; direction state SHALL exist only in this build.
REQ-028 Without LANTERN_BOUNCE_EN, mode 10 SHALL behave identically to mode 00, including its start pattern and wrap.

Verification (N_LED=4, BASE_DIV=10, STEP_DIV=2, MIN_DIV=2, bounce enabled unless stated)
REQ-029 rst low, then released; mode=00, speed=0 -> led=1000, then step every 10 cycles: 0100, 0010, 0001, 1000 with wrap on the 4th.
REQ-030 mode=10, speed=3 (P=4) -> led sequence 1000, 0100, 0010, 0001, 0010, 0100, 1000, with wrap only on the final 1000, at a step every 4 cycles.
REQ-031 mode=11, speed=9 (saturates to P=2) -> 1000, 1100, 1110, 1111, 1000 with wrap, stepping every 2 cycles.
REQ-032 stop=1 for 25 cycles mid-period in mode 01 -> led, count and outputs frozen; after stop=0, the remaining count completes with no extra step.
REQ-033 Mode changed 00->01 between steps -> at the next step led=0001, wrap=0; rst asserted mid-period -> led=1000 immediately.
REQ-034 Build without LANTERN_BOUNCE_EN, mode=10 -> sequence identical to REQ-029.

Source files
------------

// File: rtl/lantern_multi.sv
// Lantern LED sequencer: programmable-rate step timer driving shift, bounce and bar-fill patterns.
// Define LANTERN_BOUNCE_EN to build the bounce pattern for mode 10; otherwise mode 10 runs as mode 00.
module lantern_multi #(
    parameter int N_LED    = 18,
    parameter int BASE_DIV = 5000000,
    parameter int STEP_DIV = 500000,
    parameter int MIN_DIV  = 1000,
    parameter int SPEED_W  = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stop,
    input  logic [1:0]         mode,
    input  logic [SPEED_W-1:0] speed,
    output logic [N_LED-1:0]   led,
    output logic               step,
    output logic               wrap
);

    localparam logic [N_LED-1:0] MSB_ONLY = {1'b1, {(N_LED-1){1'b0}}};
    localparam logic [N_LED-1:0] LSB_ONLY = N_LED'(1);

`ifdef LANTERN_BOUNCE_EN
    typedef enum logic {DIR_DOWN, DIR_UP} dir_e;
    dir_e dir_q, dir_d;
`endif

    logic [31:0]      cnt_q, cnt_d;
    logic [N_LED-1:0] led_q, led_d;
    logic [1:0]       mode_q, mode_d;
    logic             step_q, step_d;
    logic             wrap_q, wrap_d;

    logic [63:0]      prod;
    logic [31:0]      period;
    logic             hit;
    logic [1:0]       mode_eff;
    logic [N_LED-1:0] inv_led;
    logic             one_hot;
    logic             bar_ok;

    // Period in 64-bit arithmetic so large speed settings cannot wrap before saturation.
    always_comb begin
        prod = 64'(speed) * 64'(STEP_DIV);
        if (prod > 64'(BASE_DIV - MIN_DIV)) begin
            period = 32'(MIN_DIV);
        end else begin
            period = 32'(64'(BASE_DIV) - prod);
        end
        hit = (cnt_q >= (period - 32'd1));
    end

    always_comb begin
`ifdef LANTERN_BOUNCE_EN
        mode_eff = mode;
`else
        mode_eff = (mode == 2'b10) ? 2'b00 : mode;
`endif
        inv_led = ~led_q;
        one_hot = $onehot(led_q);
        bar_ok  = led_q[N_LED-1] && ((inv_led & (inv_led + 1'b1)) == '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= '0;
            led_q  <= MSB_ONLY;
            mode_q <= 2'b00;
            step_q <= 1'b0;
            wrap_q <= 1'b0;
`ifdef LANTERN_BOUNCE_EN
            dir_q  <= DIR_DOWN;
`endif
        end else begin
            cnt_q  <= cnt_d;
            led_q  <= led_d;
            mode_q <= mode_d;
            step_q <= step_d;
            wrap_q <= wrap_d;
`ifdef LANTERN_BOUNCE_EN
            dir_q  <= dir_d;
`endif
        end
    end

    always_comb begin
        cnt_d  = cnt_q;
        led_d  = led_q;
        mode_d = mode_q;
        step_d = 1'b0;
        wrap_d = 1'b0;
`ifdef LANTERN_BOUNCE_EN
        dir_d  = dir_q;
`endif
        if (!stop) begin
            if (hit) begin
                cnt_d  = '0;
                step_d = 1'b1;
                if (mode_eff != mode_q) begin
                    mode_d = mode_eff;
                    led_d  = (mode_eff == 2'b01) ? LSB_ONLY : MSB_ONLY;
`ifdef LANTERN_BOUNCE_EN
                    dir_d  = DIR_DOWN;
`endif
                end else begin
                    case (mode_q)
                        2'b01: begin
                            if (!one_hot) begin
                                led_d = LSB_ONLY;
                            end else if (led_q[N_LED-1]) begin
                                led_d  = LSB_ONLY;
                                wrap_d = 1'b1;
                            end else begin
                                led_d = led_q << 1;
                            end
                        end
                        2'b11: begin
                            if (!bar_ok) begin
                                led_d = MSB_ONLY;
                            end else if (&led_q) begin
                                led_d  = MSB_ONLY;
                                wrap_d = 1'b1;
                            end else begin
                                led_d = {1'b1, led_q[N_LED-1:1]};
                            end
                        end
`ifdef LANTERN_BOUNCE_EN
                        // Direction flips on arrival at an end so each end is lit for one step only.
                        2'b10: begin
                            if (!one_hot) begin
                                led_d = MSB_ONLY;
                                dir_d = DIR_DOWN;
                            end else if (dir_q == DIR_DOWN) begin
                                if (led_q[0]) begin
                                    led_d = led_q << 1;
                                    dir_d = DIR_UP;
                                end else begin
                                    led_d = led_q >> 1;
                                    if (led_q[1]) dir_d = DIR_UP;
                                end
                            end else begin
                                if (led_q[N_LED-1]) begin
                                    led_d = led_q >> 1;
                                    dir_d = DIR_DOWN;
                                end else begin
                                    led_d = led_q << 1;
                                    if (led_q[N_LED-2]) begin
                                        dir_d  = DIR_DOWN;
                                        wrap_d = 1'b1;
                                    end
                                end
                            end
                        end
`endif
                        default: begin
                            if (!one_hot) begin
                                led_d = MSB_ONLY;
                            end else if (led_q[0]) begin
                                led_d  = MSB_ONLY;
                                wrap_d = 1'b1;
                            end else begin
                                led_d = led_q >> 1;
                            end
                        end
                    endcase
                end
            end else begin
                cnt_d = cnt_q + 32'd1;
            end
        end
    end

    assign led  = led_q;
    assign step = step_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_lantern_multi.sv
// Directed bench for lantern_multi with N_LED=4, BASE_DIV=10, STEP_DIV=2, MIN_DIV=2.
module tb_lantern_multi;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stop = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic [15:0] speed = 16'd0;
    logic [3:0]  led;
    logic        step;
    logic        wrap;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    lantern_multi #(
        .N_LED(4),
        .BASE_DIV(10),
        .STEP_DIV(2),
        .MIN_DIV(2),
        .SPEED_W(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .stop(stop),
        .mode(mode),
        .speed(speed),
        .led(led),
        .step(step),
        .wrap(wrap)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns the number of cycles until step is seen (-1 on timeout) and whether wrap appeared without step.
    task automatic next_step(input int budget, output int n, output logic stray);
        n = 0;
        stray = 1'b0;
        do begin
            tick();
            n++;
            if (wrap === 1'b1 && step !== 1'b1) stray = 1'b1;
        end while (step !== 1'b1 && n < budget);
        if (step !== 1'b1) n = -1;
    endtask

    task automatic test_reset();
        logic [3:0] el [4] = '{4'b0100, 4'b0010, 4'b0001, 4'b1000};
        logic       ew [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        int n;
        logic stray;
        rst = 1'b0;
        mode = 2'b00;
        speed = 16'd0;
        tick();
        tick();
        total++;
        if (led !== 4'b1000 || step !== 1'b0 || wrap !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: got led=%b step=%b wrap=%b, want led=1000 step=0 wrap=0", led, step, wrap);
        end
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            next_step(30, n, stray);
            total++;
            if (n !== 10 || led !== el[i] || wrap !== ew[i] || stray) begin
                bad++;
                $display("FAIL shift_right[%0d]: got cycles=%0d led=%b wrap=%b stray=%b, want cycles=10 led=%b wrap=%b stray=0",
                         i, n, led, wrap, stray, el[i], ew[i]);
            end
        end
    endtask

    task automatic test_speed_change();
        int n;
        logic stray;
        for (int i = 0; i < 5; i++) tick();
        speed = 16'd3;
        next_step(30, n, stray);
        total++;
        if (n !== 1 || led !== 4'b0100 || wrap !== 1'b0) begin
            bad++;
            $display("FAIL speed_drop_step: got cycles=%0d led=%b wrap=%b, want cycles=1 led=0100 wrap=0", n, led, wrap);
        end
        next_step(30, n, stray);
        total++;
        if (n !== 4 || led !== 4'b0010) begin
            bad++;
            $display("FAIL speed3_period: got cycles=%0d led=%b, want cycles=4 led=0010", n, led);
        end
        speed = 16'd4;
        next_step(30, n, stray);
        total++;
        if (n !== 2 || led !== 4'b0001) begin
            bad++;
            $display("FAIL speed4_period: got cycles=%0d led=%b, want cycles=2 led=0001", n, led);
        end
    endtask

    task automatic test_bounce();
`ifdef LANTERN_BOUNCE_EN
        logic [3:0] el [7] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
        logic       ew [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
`else
        logic [3:0] el [7] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b1000, 4'b0100, 4'b0010};
        logic       ew [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
`endif
        int n;
        logic stray;
        mode = 2'b10;
        speed = 16'd3;
        for (int i = 0; i < 7; i++) begin
            next_step(30, n, stray);
            total++;
            if (n !== 4 || led !== el[i] || wrap !== ew[i] || stray) begin
                bad++;
                $display("FAIL mode10[%0d]: got cycles=%0d led=%b wrap=%b stray=%b, want cycles=4 led=%b wrap=%b stray=0",
                         i, n, led, wrap, stray, el[i], ew[i]);
            end
        end
    endtask

    task automatic test_bar();
        logic [3:0] el [5] = '{4'b1000, 4'b1100, 4'b1110, 4'b1111, 4'b1000};
        logic       ew [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        int n;
        logic stray;
        mode = 2'b11;
        speed = 16'd9;
        for (int i = 0; i < 5; i++) begin
            next_step(30, n, stray);
            total++;
            if (n !== 2 || led !== el[i] || wrap !== ew[i] || stray) begin
                bad++;
                $display("FAIL bar_fill[%0d]: got cycles=%0d led=%b wrap=%b stray=%b, want cycles=2 led=%b wrap=%b stray=0",
                         i, n, led, wrap, stray, el[i], ew[i]);
            end
        end
    endtask

    task automatic test_stop_shift_left();
        logic [3:0] el [3] = '{4'b0100, 4'b1000, 4'b0001};
        logic       ew [3] = '{1'b0, 1'b0, 1'b1};
        int n;
        logic stray;
        logic moved;
        mode = 2'b01;
        speed = 16'd0;
        next_step(30, n, stray);
        total++;
        if (n !== 10 || led !== 4'b0001 || wrap !== 1'b0) begin
            bad++;
            $display("FAIL mode01_load: got cycles=%0d led=%b wrap=%b, want cycles=10 led=0001 wrap=0", n, led, wrap);
        end
        tick();
        tick();
        tick();
        stop = 1'b1;
        moved = 1'b0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (led !== 4'b0001 || step !== 1'b0 || wrap !== 1'b0) moved = 1'b1;
        end
        total++;
        if (moved !== 1'b0) begin
            bad++;
            $display("FAIL stop_freeze: got activity=%b led=%b, want activity=0 led=0001", moved, led);
        end
        stop = 1'b0;
        next_step(30, n, stray);
        total++;
        if (n !== 7 || led !== 4'b0010 || wrap !== 1'b0) begin
            bad++;
            $display("FAIL stop_resume: got cycles=%0d led=%b wrap=%b, want cycles=7 led=0010 wrap=0", n, led, wrap);
        end
        for (int i = 0; i < 3; i++) begin
            next_step(30, n, stray);
            total++;
            if (n !== 10 || led !== el[i] || wrap !== ew[i] || stray) begin
                bad++;
                $display("FAIL shift_left[%0d]: got cycles=%0d led=%b wrap=%b stray=%b, want cycles=10 led=%b wrap=%b stray=0",
                         i, n, led, wrap, stray, el[i], ew[i]);
            end
        end
    endtask

    task automatic test_mode_change_reset();
        int n;
        logic stray;
        mode = 2'b00;
        next_step(30, n, stray);
        total++;
        if (n !== 10 || led !== 4'b1000 || wrap !== 1'b0) begin
            bad++;
            $display("FAIL mode00_load: got cycles=%0d led=%b wrap=%b, want cycles=10 led=1000 wrap=0", n, led, wrap);
        end
        tick();
        tick();
        tick();
        mode = 2'b01;
        next_step(30, n, stray);
        total++;
        if (n !== 7 || led !== 4'b0001 || wrap !== 1'b0) begin
            bad++;
            $display("FAIL mode_change_00_01: got cycles=%0d led=%b wrap=%b, want cycles=7 led=0001 wrap=0", n, led, wrap);
        end
        for (int i = 0; i < 4; i++) tick();
        rst = 1'b0;
        #1;
        total++;
        if (led !== 4'b1000 || step !== 1'b0 || wrap !== 1'b0) begin
            bad++;
            $display("FAIL async_reset: got led=%b step=%b wrap=%b, want led=1000 step=0 wrap=0", led, step, wrap);
        end
        tick();
        rst = 1'b1;
        next_step(30, n, stray);
        total++;
        if (n !== 10 || led !== 4'b0001 || wrap !== 1'b0) begin
            bad++;
            $display("FAIL reset_discards_count: got cycles=%0d led=%b wrap=%b, want cycles=10 led=0001 wrap=0", n, led, wrap);
        end
    endtask

    initial begin
        test_reset();
        test_speed_change();
        test_bounce();
        test_bar();
        test_stop_shift_left();
        test_mode_change_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
